// File: rtl/sgbm_disp_wta.sv
`default_nettype none

`ifndef DISPD
`define DISPD 64
`endif
`ifndef DISPD_BITS
`define DISPD_BITS 7
`endif
`ifndef COST_BITS
`define COST_BITS 12
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 11
`endif

// ============================================================================
// Module      : sgbm_disp_wta
// Description : Semi-global matching winner-takes-all stage. Sums four
//               aggregated path-cost vectors, finds the lowest-cost
//               disparity with a pipelined argmin tree, applies a
//               uniqueness check and tracks the output column to flag the
//               last pixel of each line.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_cost0..i_cost3    - per-disparity path costs
//               i_valid, i_rst_line - pixel strobe, start-of-line pulse
//               i_width, i_min_disp, i_max_disp, i_uniq - configuration
//               o_disp, o_invalid, o_valid, o_line_done - results
// Revision    : 1.0 - initial release
// ============================================================================
module sgbm_disp_wta (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [`DISPD*`COST_BITS-1:0]       i_cost0,
    input  logic [`DISPD*`COST_BITS-1:0]       i_cost1,
    input  logic [`DISPD*`COST_BITS-1:0]       i_cost2,
    input  logic [`DISPD*`COST_BITS-1:0]       i_cost3,
    input  logic                               i_valid,
    input  logic                               i_rst_line,
    input  logic [`WIDTH_BITS-1:0]             i_width,
    input  logic [`DISPD_BITS-1:0]             i_min_disp,
    input  logic [`DISPD_BITS-1:0]             i_max_disp,
    input  logic [6:0]                         i_uniq,
    output logic [`DISPD_BITS-1:0]             o_disp,
    output logic                               o_invalid,
    output logic                               o_valid,
    output logic                               o_line_done
);

    localparam int DISPD     = `DISPD;
    localparam int CB        = `COST_BITS;
    localparam int DB        = `DISPD_BITS;
    localparam int WB        = `WIDTH_BITS;
    localparam int SUM_BITS  = CB + 2;
    localparam int H         = $clog2(DISPD);
    localparam int N         = 1 << H;          // leaves, padded to a power of two
    localparam int PROD_BITS = SUM_BITS + 8;
    localparam int DEPTH     = H + 3;

    // Signed so that a max below min simply forces every entry.
    logic signed [DB:0] w_range;
    assign w_range = $signed({1'b0, i_max_disp}) - $signed({1'b0, i_min_disp});

    // ---------------- Stage 1: cost sum with range forcing ----------------
    logic [SUM_BITS-1:0] r_s [N];

    always_ff @(posedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (d < DISPD && d < int'(w_range)) begin
                r_s[d] <= SUM_BITS'(i_cost0[d*CB +: CB]) + SUM_BITS'(i_cost1[d*CB +: CB])
                        + SUM_BITS'(i_cost2[d*CB +: CB]) + SUM_BITS'(i_cost3[d*CB +: CB]);
            end else begin
                r_s[d] <= '1;
            end
        end
    end

    // ---------------- Stages 2..H+1: argmin tree ----------------
    // Nodes of all levels share one flat array; level l starts at
    // N - (N >> (l-1)), so the root lands at N-2.
    logic [SUM_BITS-1:0] w_lv [N-1];
    logic [SUM_BITS-1:0] w_rv [N-1];
    logic [H-1:0]        w_li [N-1];
    logic [H-1:0]        w_ri [N-1];
    logic [SUM_BITS-1:0] r_tv [N-1];
    logic [H-1:0]        r_ti [N-1];

    always_comb begin
        for (int j = 0; j < N-1; j++) begin
            w_lv[j] = '0;
            w_rv[j] = '0;
            w_li[j] = '0;
            w_ri[j] = '0;
        end
        for (int l = 1; l <= H; l++) begin
            for (int k = 0; k < N/2; k++) begin
                if (k < (N >> l)) begin
                    if (l == 1) begin
                        w_lv[k] = r_s[2*k];
                        w_rv[k] = r_s[2*k+1];
                        w_li[k] = H'(2*k);
                        w_ri[k] = H'(2*k+1);
                    end else begin
                        w_lv[N-(N>>(l-1))+k] = r_tv[N-(N>>(l-2))+2*k];
                        w_rv[N-(N>>(l-1))+k] = r_tv[N-(N>>(l-2))+2*k+1];
                        w_li[N-(N>>(l-1))+k] = r_ti[N-(N>>(l-2))+2*k];
                        w_ri[N-(N>>(l-1))+k] = r_ti[N-(N>>(l-2))+2*k+1];
                    end
                end
            end
        end
    end

    // The left child always carries the lower index, so it wins ties.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N-1; j++) begin
            if (w_rv[j] < w_lv[j]) begin
                r_tv[j] <= w_rv[j];
                r_ti[j] <= w_ri[j];
            end else begin
                r_tv[j] <= w_lv[j];
                r_ti[j] <= w_li[j];
            end
        end
    end

    // Full cost vector delayed to line up with the tree root.
    logic [SUM_BITS-1:0] r_sd [H][N];

    always_ff @(posedge clk) begin
        r_sd[0] <= r_s;
        for (int k = 1; k < H; k++) begin
            r_sd[k] <= r_sd[k-1];
        end
    end

    // ---------------- Stage H+2: uniqueness ----------------
    logic [SUM_BITS-1:0]  w_best_v;
    logic [H-1:0]         w_best_i;
    logic [PROD_BITS-1:0] w_thr;
    logic                 w_inv;
    logic [H-1:0]         r_best;
    logic                 r_inv;

    assign w_best_v = r_tv[N-2];
    assign w_best_i = r_ti[N-2];
    assign w_thr    = PROD_BITS'(w_best_v) * PROD_BITS'(8'd100 + {1'b0, i_uniq});

    always_comb begin
        w_inv = 1'b0;
        for (int d = 0; d < DISPD; d++) begin
            if (d < int'(w_range)
                && (d > int'(w_best_i) + 1 || d < int'(w_best_i) - 1)
                && (PROD_BITS'(r_sd[H-1][d]) * PROD_BITS'(100) < w_thr)) begin
                w_inv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_best <= w_best_i;
        r_inv  <= w_inv;
    end

    // ---------------- Control: valid and line-marker shift registers ----------------
    logic [DEPTH-1:0] r_vsr;
    logic [DEPTH-1:0] r_msr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsr <= '0;
            r_msr <= '0;
        end else begin
            r_vsr <= {r_vsr[DEPTH-2:0], i_valid};
            r_msr <= {r_msr[DEPTH-2:0], i_rst_line};
        end
    end

    // ---------------- Stage H+3: output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_disp    <= '0;
            o_invalid <= 1'b0;
        end else if (r_vsr[DEPTH-2]) begin
            o_disp    <= i_min_disp + DB'(r_best);
            o_invalid <= r_inv;
        end
    end

    assign o_valid = r_vsr[DEPTH-1];

    // ---------------- Output column counter ----------------
    logic [WB-1:0] r_col;
    logic [WB-1:0] w_col_eff;
    logic [WB-1:0] w_term;

    // A marker arriving with a pixel makes that pixel column 0.
    assign w_col_eff   = r_msr[DEPTH-1] ? '0 : r_col;
    assign w_term      = i_width - WB'(i_max_disp) - WB'(1);
    assign o_line_done = o_valid && (w_col_eff == w_term);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
        end else if (o_valid) begin
            r_col <= o_line_done ? '0 : w_col_eff + WB'(1);
        end else if (r_msr[DEPTH-1]) begin
            r_col <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sgbm_disp_wta.sv
`default_nettype none

`ifndef DISPD
`define DISPD 64
`endif
`ifndef DISPD_BITS
`define DISPD_BITS 7
`endif
`ifndef COST_BITS
`define COST_BITS 12
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 11
`endif

// ============================================================================
// Module      : tb_sgbm_disp_wta
// Description : Self-checking bench for sgbm_disp_wta. Directed cases plus
//               randomized traffic scored against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sgbm_disp_wta;

    localparam int DISPD = `DISPD;
    localparam int CB    = `COST_BITS;
    localparam int DB    = `DISPD_BITS;
    localparam int WB    = `WIDTH_BITS;
    localparam int SB    = CB + 2;
    localparam int LAT   = 9;

    logic                      clk;
    logic                      rst;
    logic [DISPD*CB-1:0]       i_cost0, i_cost1, i_cost2, i_cost3;
    logic                      i_valid, i_rst_line;
    logic [WB-1:0]             i_width;
    logic [DB-1:0]             i_min_disp, i_max_disp;
    logic [6:0]                i_uniq;
    logic [DB-1:0]             o_disp;
    logic                      o_invalid, o_valid, o_line_done;

    sgbm_disp_wta dut (
        .clk         (clk),
        .rst         (rst),
        .i_cost0     (i_cost0),
        .i_cost1     (i_cost1),
        .i_cost2     (i_cost2),
        .i_cost3     (i_cost3),
        .i_valid     (i_valid),
        .i_rst_line  (i_rst_line),
        .i_width     (i_width),
        .i_min_disp  (i_min_disp),
        .i_max_disp  (i_max_disp),
        .i_uniq      (i_uniq),
        .o_disp      (o_disp),
        .o_invalid   (o_invalid),
        .o_valid     (o_valid),
        .o_line_done (o_line_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int disp;
        int inv;
        int ld;
    } exp_t;

    exp_t q[$];
    int   cost [4][DISPD];
    int   cyc, errors, checks;
    int   mcol, last_disp, last_inv;
    int   m_min, m_max, m_width, m_uniq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference: sum, force out-of-range, lowest-index minimum, uniqueness.
    task automatic model_pixel(output int disp, output int inv);
        longint s [DISPD];
        int     rng, best;
        rng = m_max - m_min;
        for (int d = 0; d < DISPD; d++) begin
            if (d >= rng) s[d] = (longint'(1) << SB) - 1;
            else          s[d] = cost[0][d] + cost[1][d] + cost[2][d] + cost[3][d];
        end
        best = 0;
        for (int d = 1; d < DISPD; d++) if (s[d] < s[best]) best = d;
        inv = 0;
        for (int d = 0; d < DISPD; d++) begin
            if (d < rng && (d - best > 1 || best - d > 1) && s[d] * 100 < s[best] * (100 + m_uniq))
                inv = 1;
        end
        disp = (m_min + best) % (1 << DB);
    endtask

    task automatic set_costs(input int v);
        for (int k = 0; k < 4; k++)
            for (int d = 0; d < DISPD; d++) cost[k][d] = v;
    endtask

    task automatic rand_costs(input int maxv);
        for (int k = 0; k < 4; k++)
            for (int d = 0; d < DISPD; d++) cost[k][d] = $urandom_range(0, maxv);
    endtask

    task automatic step(input bit v, input bit rl, input bit r);
        exp_t e;
        int   term, dp, iv;
        for (int d = 0; d < DISPD; d++) begin
            i_cost0[d*CB +: CB] = cost[0][d][CB-1:0];
            i_cost1[d*CB +: CB] = cost[1][d][CB-1:0];
            i_cost2[d*CB +: CB] = cost[2][d][CB-1:0];
            i_cost3[d*CB +: CB] = cost[3][d][CB-1:0];
        end
        i_valid    = v;
        i_rst_line = rl;
        rst        = r;
        i_min_disp = m_min[DB-1:0];
        i_max_disp = m_max[DB-1:0];
        i_width    = m_width[WB-1:0];
        i_uniq     = m_uniq[6:0];
        if (r) begin
            q.delete();
            mcol      = 0;
            last_disp = 0;
            last_inv  = 0;
        end else begin
            if (rl) mcol = 0;
            if (v) begin
                model_pixel(dp, iv);
                term   = (m_width - m_max - 1) & ((1 << WB) - 1);
                e.due  = cyc + LAT - 1;
                e.disp = dp;
                e.inv  = iv;
                e.ld   = (mcol == term) ? 1 : 0;
                mcol   = e.ld ? 0 : (mcol + 1) % (1 << WB);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("valid",     64'(o_valid),     64'(1));
            check("disp",      64'(o_disp),      64'(e.disp));
            check("invalid",   64'(o_invalid),   64'(e.inv));
            check("line_done", 64'(o_line_done), 64'(e.ld));
            last_disp = e.disp;
            last_inv  = e.inv;
        end else begin
            check("valid_idle",     64'(o_valid),     64'(0));
            check("line_done_idle", 64'(o_line_done), 64'(0));
            check("disp_hold",      64'(o_disp),      64'(last_disp));
            check("invalid_hold",   64'(o_invalid),   64'(last_inv));
        end
        cyc++;
    endtask

    task automatic drain();
        repeat (LAT + 2) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0; errors = 0; checks = 0; mcol = 0; last_disp = 0; last_inv = 0;
        m_min = 0; m_max = 64; m_width = 100; m_uniq = 10;
        set_costs(0);

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Clear winner at index 5, fixed latency
        set_costs(10);
        for (int k = 0; k < 4; k++) cost[k][5] = 0;
        step(1'b1, 1'b1, 1'b0);
        drain();

        // Tie on the minimum: lower index wins, uniqueness fails
        set_costs(0);
        for (int d = 0; d < DISPD; d++) cost[0][d] = 200;
        cost[0][3] = 40; cost[0][7] = 40;
        step(1'b1, 1'b0, 1'b0);
        drain();

        // Near-minimum far away invalidates; adjacent neighbour is excluded
        set_costs(0);
        for (int d = 0; d < DISPD; d++) cost[0][d] = 500;
        cost[0][10] = 100; cost[0][11] = 105; cost[0][30] = 108;
        step(1'b1, 1'b0, 1'b0);
        cost[0][30] = 120;
        step(1'b1, 1'b0, 1'b0);
        drain();

        // Restricted range: zero costs above the range are ignored
        m_min = 4; m_max = 32;
        repeat (6) begin
            rand_costs(300);
            for (int k = 0; k < 4; k++)
                for (int d = 28; d < DISPD; d++) cost[k][d] = 0;
            step(1'b1, 1'b0, 1'b0);
        end
        drain();

        // Line accounting: contiguous, gapped, then excess pixels
        m_min = 0; m_max = 64; m_width = 100;
        for (int i = 0; i < 36; i++) begin
            rand_costs(4095);
            step(1'b1, (i == 0), 1'b0);
        end
        drain();
        for (int i = 0; i < 36; i++) begin
            rand_costs(15);
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0);
            step(1'b1, (i == 0), 1'b0);
        end
        drain();
        for (int i = 0; i < 80; i++) begin
            rand_costs(15);
            step(1'b1, (i == 0), 1'b0);
        end
        drain();

        // Reset with pixels in flight; column restarts at 0
        for (int i = 0; i < 5; i++) begin
            rand_costs(4095);
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        drain();
        for (int i = 0; i < 36; i++) begin
            rand_costs(4095);
            step(1'b1, 1'b0, 1'b0);
        end
        drain();

        // Randomized traffic with varied configuration
        for (int g = 0; g < 4; g++) begin
            m_min   = $urandom_range(0, 20);
            m_max   = $urandom_range(m_min + 1, 64);
            m_width = $urandom_range(m_max + 1, m_max + 40);
            m_uniq  = $urandom_range(0, 100);
            for (int i = 0; i < 150; i++) begin
                rand_costs(($urandom_range(0, 1) == 0) ? 15 : 4095);
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0), 1'b0);
            end
            drain();
        end

        check("queue_empty", 64'(q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
